littlecpu_dmem: RTL and testbench

Synthesizable data-memory slave sitting directly downstream of the littlecpu data port. It is the production replacement for the bench memory model.
- Services CPU loads/stores to an on-chip word RAM with byte write strobes.
- Provides one memory-mapped console transmit register backed by a small FIFO with a valid/ready byte stream output.
- Flags accesses to unmapped addresses with an error response.

---
 rtl/littlecpu_dmem.sv | 167 ++++++++++++++++
 tb/tb_littlecpu_dmem.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/littlecpu_dmem.sv
// littlecpu data-memory slave: word RAM with byte strobes, console TX FIFO, unmapped-address error.
// Optional access counters (stat_reads/stat_writes/stat_errs) when LITTLECPU_DMEM_STATS_EN is defined.
`timescale 1ns/1ps
module littlecpu_dmem #(
    parameter int unsigned DEPTH        = 256,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_ready,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_valid,
    output logic [31:0] mem_rdata,
    output logic        mem_err,
    output logic        con_valid,
    input  logic        con_ready,
    output logic [7:0]  con_data
`ifdef LITTLECPU_DMEM_STATS_EN
    ,
    output logic [31:0] stat_reads,
    output logic [31:0] stat_writes,
    output logic [31:0] stat_errs
`endif
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam logic [31:0] RAM_BYTES = 32'(DEPTH * 4);

    typedef enum logic [1:0] {IDLE, RESP, CWAIT} state_t;

    state_t           state;
    logic [31:0]      ram [DEPTH];
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [CNT_W-1:0] count;
    logic [7:0]       pend_byte;

    logic          accept, ram_hit, con_hit, ram_we;
    logic [AW-1:0] ram_idx;
    logic          fifo_full, fifo_empty, pop, push_req, can_push, push;
    logic [7:0]    push_data;
    logic [31:0]   status;

    always_comb begin
        accept     = (state == IDLE) && mem_ready && !mem_valid;
        ram_hit    = mem_addr < RAM_BYTES;
        con_hit    = !ram_hit && ({mem_addr[31:2], 2'b00} == CONSOLE_ADDR);
        ram_idx    = mem_addr[AW+1:2];
        ram_we     = accept && ram_hit && reset;
        fifo_empty = (count == '0);
        fifo_full  = (count == CNT_W'(FIFO_DEPTH));
        status     = {30'b0, fifo_full, fifo_empty};
        pop        = !fifo_empty && con_ready;
        // A pop on the same edge frees the slot, so a full FIFO can still take the push.
        can_push   = !fifo_full || pop;
        push_req   = (state == CWAIT) || (accept && con_hit && mem_wstrb[0]);
        push_data  = (state == CWAIT) ? pend_byte : mem_wdata[7:0];
        push       = push_req && can_push;
        con_valid  = !fifo_empty;
        con_data   = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
    end

    // NOTE: storage arrays carry no reset so they map onto RAM macros; contents survive reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we && mem_wstrb[b])
                ram[ram_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
        if (push)
            fifo_mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_rdata <= '0;
            mem_err   <= 1'b0;
            pend_byte <= '0;
        end else begin
            case (state)
                IDLE: begin
                    mem_valid <= 1'b0;
                    mem_err   <= 1'b0;
                    if (accept) begin
                        if (ram_hit) begin
                            mem_rdata <= ram[ram_idx];
                            mem_valid <= 1'b1;
                            state     <= RESP;
                        end else if (con_hit) begin
                            mem_rdata <= status;
                            if (mem_wstrb[0] && !can_push) begin
                                pend_byte <= mem_wdata[7:0];
                                state     <= CWAIT;
                            end else begin
                                mem_valid <= 1'b1;
                                state     <= RESP;
                            end
                        end else begin
                            mem_rdata <= '0;
                            mem_err   <= 1'b1;
                            mem_valid <= 1'b1;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    mem_valid <= 1'b0;
                    mem_err   <= 1'b0;
                    state     <= IDLE;
                end
                CWAIT: begin
                    if (can_push) begin
                        mem_rdata <= status;
                        mem_valid <= 1'b1;
                        state     <= RESP;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LITTLECPU_DMEM_STATS_EN
    logic resp_write;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_write  <= 1'b0;
            stat_reads  <= '0;
            stat_writes <= '0;
            stat_errs   <= '0;
        end else begin
            if (accept)
                resp_write <= |mem_wstrb;
            if (mem_valid) begin
                if (mem_err)
                    stat_errs <= stat_errs + 32'd1;
                else if (resp_write)
                    stat_writes <= stat_writes + 32'd1;
                else
                    stat_reads <= stat_reads + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_littlecpu_dmem.sv
// Directed self-checking bench for littlecpu_dmem: RAM access, strobes, throughput, console FIFO, errors, reset.
`timescale 1ns/1ps
module tb_littlecpu_dmem;

    localparam logic [31:0] CON = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        mem_err;
    logic        con_valid;
    logic        con_ready = 1'b0;
    logic [7:0]  con_data;
`ifdef LITTLECPU_DMEM_STATS_EN
    logic [31:0] stat_reads, stat_writes, stat_errs;
`endif

    int total = 0;
    int bad   = 0;

    littlecpu_dmem dut (
        .clk       (clk),
        .reset     (reset),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_valid (mem_valid),
        .mem_rdata (mem_rdata),
        .mem_err   (mem_err),
        .con_valid (con_valid),
        .con_ready (con_ready),
        .con_data  (con_data)
`ifdef LITTLECPU_DMEM_STATS_EN
        ,
        .stat_reads  (stat_reads),
        .stat_writes (stat_writes),
        .stat_errs   (stat_errs)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One transaction starting at posedge+#1 with the DUT idle; returns after mem_valid has dropped.
    task automatic tx(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [3:0] wstrb, output logic [31:0] rdata, output logic err,
                      output int lat);
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        lat = 1;
        while (!mem_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = mem_rdata;
        err   = mem_err;
        @(posedge clk);
        #1;
        check({tag, "_pulse_width"}, 32'(mem_valid), 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          pulses, consec, nbytes;
    logic        prev;
    logic [31:0] b2b_exp [5] = '{32'd0, 32'd0, 32'd1, 32'd1, 32'd3};
    logic [7:0]  exp_bytes [5] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65};
    logic [7:0]  got_bytes [8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_valid", 32'(mem_valid), 32'd0);
        check("rst_mem_rdata", mem_rdata, 32'd0);
        check("rst_mem_err",   32'(mem_err), 32'd0);
        check("rst_con_valid", 32'(con_valid), 32'd0);
        check("rst_con_data",  32'(con_data), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Full-word store/load at the top RAM word
        tx("sw_init", 32'h3FC, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        tx("sw", 32'h3FC, 32'h1234_5678, 4'hF, rd, er, lat);
        check("sw_old_word", rd, 32'hDEAD_BEEF);
        check("sw_err", 32'(er), 32'd0);
        check("sw_latency", 32'(lat), 32'd1);
        tx("lw", 32'h3FC, 32'h0, 4'h0, rd, er, lat);
        check("lw_data", rd, 32'h1234_5678);
        check("lw_err", 32'(er), 32'd0);
        check("lw_latency", 32'(lat), 32'd1);

        // Byte strobes and misaligned access
        tx("strb_init", 32'h10, 32'hFFFF_FFFF, 4'hF, rd, er, lat);
        tx("strb_sb", 32'h10, 32'h0000_AB00, 4'b0010, rd, er, lat);
        check("strb_old_word", rd, 32'hFFFF_FFFF);
        tx("strb_lw", 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("strb_readback", rd, 32'hFFFF_ABFF);
        tx("misalign", 32'h13, 32'h0, 4'h0, rd, er, lat);
        check("misalign_data", rd, 32'hFFFF_ABFF);
        check("misalign_err", 32'(er), 32'd0);

        // Back-to-back: mem_ready held for 10 cycles, alternating read/write
        tx("b2b_init", 32'h20, 32'h0, 4'hF, rd, er, lat);
        mem_addr = 32'h20; mem_wdata = '0; mem_wstrb = 4'h0; mem_ready = 1'b1;
        pulses = 0; consec = 0; prev = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (mem_valid) begin
                if (pulses < 5) check("b2b_rdata", mem_rdata, b2b_exp[pulses]);
                pulses++;
                if (prev) consec++;
                if (pulses % 2 == 1) begin
                    mem_wstrb = 4'hF;
                    mem_wdata = 32'(pulses);
                end else begin
                    mem_wstrb = 4'h0;
                end
            end
            prev = mem_valid;
        end
        mem_ready = 1'b0;
        check("b2b_pulses", 32'(pulses), 32'd5);
        check("b2b_consecutive", 32'(consec), 32'd0);
        @(posedge clk);
        #1;
        tx("b2b_final", 32'h20, 32'h0, 4'h0, rd, er, lat);
        check("b2b_final_word", rd, 32'd3);

        // Console backpressure
        con_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx("con_wr", CON, {24'h0, exp_bytes[i]}, 4'h1, rd, er, lat);
            check("con_wr_latency", 32'(lat), 32'd1);
            check("con_wr_err", 32'(er), 32'd0);
        end
        tx("con_status_full", CON + 32'h2, 32'h0, 4'h0, rd, er, lat);
        check("con_status_full", rd, 32'h2);
        mem_addr = CON; mem_wdata = 32'h65; mem_wstrb = 4'h1; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        check("cwait_no_valid0", 32'(mem_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("cwait_no_valid3", 32'(mem_valid), 32'd0);
        check("cwait_head", 32'(con_data), 32'h61);
        con_ready = 1'b1;
        nbytes = 0;
        for (int c = 0; c < 20 && con_valid; c++) begin
            got_bytes[nbytes % 8] = con_data;
            nbytes++;
            @(posedge clk);
            #1;
            if (c == 0) check("cwait_resp_after_push", 32'(mem_valid), 32'd1);
        end
        con_ready = 1'b0;
        check("con_byte_count", 32'(nbytes), 32'd5);
        for (int i = 0; i < 5; i++)
            check("con_byte", 32'(got_bytes[i]), 32'(exp_bytes[i]));

        // Unmapped error, then status with FIFO empty
        tx("err", 32'h0000_0400, 32'h0, 4'h0, rd, er, lat);
        check("err_flag", 32'(er), 32'd1);
        check("err_rdata", rd, 32'd0);
        check("err_latency", 32'(lat), 32'd1);
        tx("con_status", CON, 32'h0, 4'h0, rd, er, lat);
        check("con_status_empty", rd, 32'h1);
        check("con_status_err", 32'(er), 32'd0);
        tx("con_nostrb", CON, 32'h7A, 4'b0010, rd, er, lat);
        check("con_nostrb_latency", 32'(lat), 32'd1);
        check("con_nostrb_no_push", 32'(con_valid), 32'd0);

        // Reset while in RESP
        mem_addr = 32'h40; mem_wdata = 32'hCAFE_F00D; mem_wstrb = 4'hF; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        check("rst_resp_pre", 32'(mem_valid), 32'd1);
        #1 reset = 1'b0;
        #1 check("rst_resp_valid", 32'(mem_valid), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;

        // Reset while in CWAIT
        for (int i = 0; i < 4; i++)
            tx("rst_fill", CON, {24'h0, exp_bytes[i]}, 4'h1, rd, er, lat);
        mem_addr = CON; mem_wdata = 32'h65; mem_wstrb = 4'h1; mem_ready = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b0;
        check("rst_cwait_pre", 32'(mem_valid), 32'd0);
        #1 reset = 1'b0;
        #1;
        check("rst_cwait_valid", 32'(mem_valid), 32'd0);
        check("rst_cwait_con_valid", 32'(con_valid), 32'd0);
        check("rst_cwait_con_data", 32'(con_data), 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (mem_valid) pulses++;
        end
        check("rst_dropped_resp", 32'(pulses), 32'd0);
        check("rst_fifo_empty", 32'(con_valid), 32'd0);
        tx("rst_retain", 32'h3FC, 32'h0, 4'h0, rd, er, lat);
        check("rst_retain_data", rd, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
